fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer for the 2A03 core. It sits directly downstream of the program counter. It takes PC_H/PC_L as the memory address and reads the opcode and up to two operand bytes. It pulses PCinc once per byte consumed. It then presents the assembled instruction to the decode/execute control for one cycle.

## Interface

Parameters:
- none; the address is fixed at 16 bits and data at 8 bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to fetch the next instruction; sampled only in IDLE.
- pc_l  input  8  PC low byte from the PC register.
- pc_h  input  8  PC high byte from the PC register.
- mem_in  input  8  memory read data, valid when rdy=1 during a read.
- rdy  input  1  memory ready; 0 stalls the current read (6502 RDY semantics).
- op_len  input  2  instruction length in bytes, decoded combinationally from the opcode output; 0 is treated as 1.
- addr  output  16  memory address, always {pc_h, pc_l} (combinational).
- mem_rd  output  1  read strobe, high in FETCH_OP, FETCH_LO and FETCH_HI (combinational).
- PCinc  output  1  PC increment, equal to mem_rd & rdy (combinational).
- opcode  output  8  latched opcode byte.
- operand_l  output  8  latched first operand byte.
- operand_h  output  8  latched second operand byte.
- instr_valid  output  1  one-cycle pulse when the instruction is complete.
- busy  output  1  high in every state except IDLE.

## Operation

States: IDLE, FETCH_OP, LEN, FETCH_LO, FETCH_HI, DONE.

Transitions:
- IDLE: goes to FETCH_OP on start=1.
- FETCH_OP: when rdy=1, latches opcode<=mem_in and goes to LEN. When rdy=0, holds with no latch.
- LEN: issues no memory access and samples op_len. The next state is:
  - op_len of 0 or 1: DONE.
  - op_len of 2 or 3: FETCH_LO.
  - The LEN decision is stored in a 1-bit flag need_hi (op_len==3).
- FETCH_LO: when rdy=1, latches operand_l<=mem_in. Goes to FETCH_HI if need_hi, else DONE.
- FETCH_HI: when rdy=1, latches operand_h<=mem_in and goes to DONE.
- DONE: instr_valid=1 for this cycle, then goes to IDLE unconditionally.

Operand handling:
- At FETCH_OP entry, operand_l and operand_h are cleared to 0x00.
- A 1-byte instruction therefore reports both operands as 0x00.
- A 2-byte instruction reports operand_h as 0x00.

Handshake and PC interaction:
- The fetch unit never modifies the PC directly.
- Every accepted byte (rdy=1 in a fetch state) raises PCinc in that same cycle, so the PC advances at the same posedge the byte is latched.
- Address wrap from 0xFFFF to 0x0000 is handled by the PC. The next byte is read from 0x0000 with no special case here.
- Upstream control must not assert load_pc_h, load_pc_l or load_pc_h_mem while busy=1.

Other rules:
- start while busy=1 is ignored and is not queued.
- start in the DONE cycle is ignored.
- opcode, operand_l and operand_h hold their values after DONE until the next FETCH_OP entry.

Reset (asynchronous, at any time, including mid-fetch):
- State goes to IDLE.
- opcode, operand_l, operand_h, need_hi, instr_valid and busy all go to 0.
- mem_rd=0 and PCinc=0.
- addr continues to follow the PC.

## Timing

- Cycle numbering: cycle 0 is the cycle with start=1 in IDLE. All counts below assume rdy=1 throughout.
- 1-byte instruction: FETCH_OP c1, LEN c2, DONE c3. instr_valid is high in c3. Total 3 cycles, 1 PCinc.
- 2-byte instruction: FETCH_OP c1, LEN c2, FETCH_LO c3, DONE c4. 2 PCinc.
- 3-byte instruction: FETCH_OP c1, LEN c2, FETCH_LO c3, FETCH_HI c4, DONE c5. 3 PCinc.
- Each cycle with rdy=0 in a fetch state adds exactly one cycle. No PCinc is issued and no latch occurs in that cycle.
- rdy is ignored in IDLE, LEN and DONE.
- busy rises in the cycle after start is sampled and falls in the cycle after DONE.
- addr, mem_rd and PCinc are combinational from state, rdy and the PC. All other outputs are registered.

## Test plan

- **NOP fetch.** PC=0x8000, mem[0x8000]=0xEA, op_len=1, start pulse. Required: opcode=0xEA, operands=0x00, instr_valid in c3, exactly 1 PCinc, PC=0x8001.
- **JMP fetch.** PC=0x8000, mem=4C 34 12, op_len=3. Required: opcode=0x4C, operand_l=0x34, operand_h=0x12, instr_valid in c5, 3 PCinc, PC=0x8003.
- **RDY stall.** Same JMP stimulus, with rdy held 0 for 2 cycles in FETCH_LO. Required: instr_valid in c7, still exactly 3 PCinc, operand_l=0x34.
- **Ignored start.** start held high throughout the JMP fetch. Required: only one fetch sequence runs. A new FETCH_OP begins only after IDLE is re-entered, in the cycle after DONE.
- **Mid-fetch reset.** Assert reset during FETCH_HI. Required: busy=0, opcode=0x00, no instr_valid, PCinc=0 immediately. The next start refetches from the current PC.
- **Wrap.** PC=0xFFFF, mem[0xFFFF]=0xA9, mem[0x0000]=0x05, op_len=2. Required: addr goes 0xFFFF then 0x0000, operand_l=0x05, PC ends at 0x0001.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch sequencer for the 2A03 core. It reads the  |
// |               opcode and up to two operand bytes at the current PC and      |
// |               pulses PCinc once for each byte it accepts. It then presents |
// |               the assembled instruction for one cycle on instr_valid.      |
// | Ports       : clk, reset (async, active-high)                             |
// |               start        - begin a fetch (sampled only while idle)       |
// |               pc_l/pc_h    - current PC, used directly as the address      |
// |               mem_in, rdy  - memory read data / ready (0 stalls a read)    |
// |               op_len       - instruction length decoded from opcode        |
// |               addr, mem_rd, PCinc - combinational memory/PC controls       |
// |               opcode, operand_l, operand_h, instr_valid, busy - registered |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pc_l,
  input  logic [7:0]  pc_h,
  input  logic [7:0]  mem_in,
  input  logic        rdy,
  input  logic [1:0]  op_len,
  output logic [15:0] addr,
  output logic        mem_rd,
  output logic        PCinc,
  output logic [7:0]  opcode,
  output logic [7:0]  operand_l,
  output logic [7:0]  operand_h,
  output logic        instr_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_OP = 3'd1,
    S_LEN      = 3'd2,
    S_FETCH_LO = 3'd3,
    S_FETCH_HI = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t     r_state;
  logic       r_need_hi;
  logic [7:0] r_opcode;
  logic [7:0] r_operand_l;
  logic [7:0] r_operand_h;
  logic       r_instr_valid;
  logic       r_busy;

  logic       w_mem_rd;
  logic       w_accept;

  // A read is in flight in any of the three fetch states; a byte is consumed
  // (and the PC told to advance) only when memory is ready in that cycle.
  assign w_mem_rd = (r_state == S_FETCH_OP) || (r_state == S_FETCH_LO) ||
                    (r_state == S_FETCH_HI);
  assign w_accept = w_mem_rd & rdy;

  assign addr        = {pc_h, pc_l};
  assign mem_rd      = w_mem_rd;
  assign PCinc       = w_accept;
  assign opcode      = r_opcode;
  assign operand_l   = r_operand_l;
  assign operand_h   = r_operand_h;
  assign instr_valid = r_instr_valid;
  assign busy        = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_need_hi     <= 1'b0;
      r_opcode      <= 8'h00;
      r_operand_l   <= 8'h00;
      r_operand_h   <= 8'h00;
      r_instr_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // instr_valid is a single-cycle pulse; only the transitions into DONE
      // below raise it again.
      r_instr_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_FETCH_OP;
            r_busy      <= 1'b1;
            // Short instructions must report unused operand bytes as zero.
            r_operand_l <= 8'h00;
            r_operand_h <= 8'h00;
          end
        end
        S_FETCH_OP: begin
          if (rdy) begin
            r_opcode <= mem_in;
            r_state  <= S_LEN;
          end
        end
        S_LEN: begin
          // op_len is decoded from the opcode latched on the previous edge,
          // so it is only trustworthy from this state on.
          r_need_hi <= (op_len == 2'd3);
          if (op_len[1]) begin
            r_state <= S_FETCH_LO;
          end else begin
            r_state       <= S_DONE;
            r_instr_valid <= 1'b1;
          end
        end
        S_FETCH_LO: begin
          if (rdy) begin
            r_operand_l <= mem_in;
            if (r_need_hi) begin
              r_state <= S_FETCH_HI;
            end else begin
              r_state       <= S_DONE;
              r_instr_valid <= 1'b1;
            end
          end
        end
        S_FETCH_HI: begin
          if (rdy) begin
            r_operand_h   <= mem_in;
            r_state       <= S_DONE;
            r_instr_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // A start seen here is dropped; the next fetch needs start in IDLE.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                                |
// | Description : Self-checking bench for fetch_unit. Models memory, the PC    |
// |               register and the opcode length decoder, predicts each        |
// |               instruction into a scoreboard queue and checks it when       |
// |               instr_valid appears.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  pc_l, pc_h, mem_in;
  logic [1:0]  op_len;
  logic [15:0] addr;
  logic        mem_rd, PCinc, instr_valid, busy;
  logic [7:0]  opcode, operand_l, operand_h;

  logic [7:0]  mem [0:65535];
  logic [1:0]  len_tab [0:255];
  logic [15:0] pc = 16'h0000;
  logic        ld_en = 1'b0;
  logic [15:0] ld_val = 16'h0000;

  int cyc = 0;
  int pcinc_total = 0;
  int n_valid = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  opl;
    logic [7:0]  oph;
    int          vcyc;
    logic [15:0] pc_end;
    int          inc_base;
    int          len;
  } exp_t;

  exp_t q[$];

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc_l        (pc_l),
    .pc_h        (pc_h),
    .mem_in      (mem_in),
    .rdy         (rdy),
    .op_len      (op_len),
    .addr        (addr),
    .mem_rd      (mem_rd),
    .PCinc       (PCinc),
    .opcode      (opcode),
    .operand_l   (operand_l),
    .operand_h   (operand_h),
    .instr_valid (instr_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Upstream PC register and its environment.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (PCinc) pcinc_total <= pcinc_total + 1;
    if (ld_en) pc <= ld_val;
    else if (PCinc) pc <= pc + 16'd1;
  end

  assign pc_l = pc[7:0];
  assign pc_h = pc[15:8];
  // Garbage on the bus while not ready exposes any latch during a stall.
  assign mem_in = rdy ? mem[addr] : ~mem[addr];
  assign op_len = len_tab[opcode];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle (relative to start) of the DONE cycle, walking the bytes in order:
  // each read waits for a ready cycle, one decode cycle follows the opcode.
  function automatic int model_done(input int len, input logic [31:0] plan);
    int c = 1;
    while (!plan[c[4:0]]) c++;
    c++;
    c++;
    for (int b = 1; b < len; b++) begin
      while (!plan[c[4:0]]) c++;
      c++;
    end
    return c;
  endfunction

  task automatic predict(input logic [15:0] p, input int n0, input logic [31:0] plan,
                         input int inc_base, output exp_t e);
    logic [15:0] a1, a2;
    logic [7:0]  op;
    int          l;
    a1 = p + 16'd1;
    a2 = p + 16'd2;
    op = mem[p];
    l  = int'(len_tab[op]);
    if (l == 0) l = 1;
    e.op       = op;
    e.opl      = (l >= 2) ? mem[a1] : 8'h00;
    e.oph      = (l == 3) ? mem[a2] : 8'h00;
    e.len      = l;
    e.pc_end   = p + 16'(l);
    e.vcyc     = n0 + model_done(l, plan);
    e.inc_base = inc_base;
  endtask

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    check("addr_follows_pc", {16'h0, addr}, {16'h0, pc_h, pc_l});
    if (instr_valid) begin
      n_valid++;
      if (q.size() == 0) begin
        check("unexpected_instr_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("opcode", {24'h0, opcode}, {24'h0, e.op});
        check("operand_l", {24'h0, operand_l}, {24'h0, e.opl});
        check("operand_h", {24'h0, operand_h}, {24'h0, e.oph});
        check("valid_cycle", cyc, e.vcyc);
        check("pc_end", {16'h0, pc}, {16'h0, e.pc_end});
        check("pcinc_count", pcinc_total - e.inc_base, e.len);
        check("busy_in_done", {31'h0, busy}, 32'd1);
      end
    end
  end

  // Ends at posedge+#1 of cycle 0 with the PC at the fetch address.
  task automatic load_pc(input logic [15:0] p);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_val = p; start = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] p, input bit do_load, input logic [31:0] plan);
    exp_t e;
    int   base;
    bit   seen;
    if (do_load) load_pc(p);
    else begin
      @(posedge clk); #1;
    end
    predict(pc, cyc, plan, pcinc_total, e);
    q.push_back(e);
    base  = n_valid;
    start = 1'b1;
    rdy   = plan[0];
    seen  = 1'b0;
    for (int c = 1; c < 32 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rdy   = plan[c[4:0]];
      if (c == 1) check("busy_rise", {31'h0, busy}, 32'd1);
      if (n_valid > base) begin
        seen = 1'b1;
        check("busy_fall", {31'h0, busy}, 32'd0);
      end
    end
    if (!seen) begin
      check("instr_timeout", 32'd0, 32'd1);
      q.delete();
    end
    rdy = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1, e2;
    int   base;
    logic [31:0] plan;
    logic [15:0] p;
    bit   seen;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) len_tab[i] = 2'($urandom_range(0, 3));
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h05;
    len_tab[8'hEA] = 2'd1; len_tab[8'h4C] = 2'd3; len_tab[8'hA9] = 2'd2;

    // Reset state.
    load_pc(16'h1234);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_valid", {31'h0, instr_valid}, 32'd0);
    check("rst_opcode", {24'h0, opcode}, 32'h0);
    check("rst_operands", {16'h0, operand_h, operand_l}, 32'h0);
    check("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
    check("rst_pcinc", {31'h0, PCinc}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // NOP.
    mem[16'h8000] = 8'hEA;
    run_instr(16'h8000, 1'b1, 32'hFFFF_FFFF);
    mem[16'h8000] = 8'h4C;
    // JMP.
    run_instr(16'h8000, 1'b1, 32'hFFFF_FFFF);
    // JMP with two stall cycles in FETCH_LO (cycles 3 and 4).
    run_instr(16'h8000, 1'b1, ~32'h0000_0018);
    // Wrap from 0xFFFF to 0x0000.
    run_instr(16'hFFFF, 1'b1, 32'hFFFF_FFFF);

    // start held high through a JMP: a second fetch starts from IDLE at c6.
    load_pc(16'h8000);
    predict(pc, cyc, 32'hFFFF_FFFF, pcinc_total, e1);
    predict(16'h8003, cyc + 6, 32'hFFFF_FFFF, pcinc_total + 3, e2);
    q.push_back(e1);
    q.push_back(e2);
    base  = n_valid;
    start = 1'b1;
    rdy   = 1'b1;
    seen  = 1'b0;
    for (int c = 1; c < 32 && !seen; c++) begin
      @(posedge clk); #1;
      if (c == 7) start = 1'b0;
      if (c == 6) check("busy_idle_between", {31'h0, busy}, 32'd0);
      if (n_valid >= base + 2) begin
        seen = 1'b1;
        check("busy_after_second", {31'h0, busy}, 32'd0);
      end
    end
    start = 1'b0;
    if (!seen) begin
      check("held_start_timeout", 32'd0, 32'd1);
      q.delete();
    end

    // Reset asserted during FETCH_HI (cycle 4).
    load_pc(16'h8000);
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("fetch_hi_reading", {31'h0, mem_rd}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'd0);
    check("midrst_opcode", {24'h0, opcode}, 32'h0);
    check("midrst_valid", {31'h0, instr_valid}, 32'd0);
    check("midrst_pcinc", {31'h0, PCinc}, 32'd0);
    check("midrst_mem_rd", {31'h0, mem_rd}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("pc_after_reset", {16'h0, pc}, 32'h0000_8002);
    run_instr(16'h0000, 1'b0, 32'hFFFF_FFFF);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      plan = {16'hFFFF, 16'($urandom | $urandom)};
      if ($urandom_range(0, 3) == 0) plan = 32'hFFFF_FFFF;
      p = 16'($urandom);
      if ($urandom_range(0, 3) == 0) p = 16'hFFFD + 16'($urandom_range(0, 2));
      run_instr(p, ($urandom_range(0, 2) == 0), plan);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
